rl_pair_gen_controller: RTL and testbench

// Sequences particle-pair generation for the range-limited force evaluation unit: walks every reference

---
 rtl/rl_pair_gen_controller_if.sv | 31 +++
 rtl/rl_pair_gen_controller.sv | 181 ++++++++++++++++++
 tb/tb_rl_pair_gen_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rl_pair_gen_controller_if.sv
// Signal bundle between the pair-generation controller (master) and the
// cell memories / filter bank it drives (slave).
interface rl_pair_gen_controller_if #(
    parameter int NUM_FILTER        = 7,
    parameter int PARTICLE_ID_WIDTH = 7
);
    logic                                          start;
    logic [PARTICLE_ID_WIDTH:0]                    ref_count;
    logic [NUM_FILTER*(PARTICLE_ID_WIDTH+1)-1:0]   nb_count;
    logic [NUM_FILTER-1:0]                         back_pressure;
    logic                                          all_buffer_empty;
    logic [PARTICLE_ID_WIDTH-1:0]                  ref_rd_addr;
    logic [PARTICLE_ID_WIDTH-1:0]                  nb_rd_addr;
    logic [PARTICLE_ID_WIDTH-1:0]                  ref_particle_id;
    logic [PARTICLE_ID_WIDTH-1:0]                  nb_particle_id;
    logic [NUM_FILTER-1:0]                         pair_valid;
    logic                                          busy;
    logic                                          done;

    modport master (
        input  start, ref_count, nb_count, back_pressure, all_buffer_empty,
        output ref_rd_addr, nb_rd_addr, ref_particle_id, nb_particle_id,
               pair_valid, busy, done
    );

    modport slave (
        output start, ref_count, nb_count, back_pressure, all_buffer_empty,
        input  ref_rd_addr, nb_rd_addr, ref_particle_id, nb_particle_id,
               pair_valid, busy, done
    );
endinterface

// File: rtl/rl_pair_gen_controller.sv
// Range-limited pair generator: for each home-cell reference particle, walks
// every neighbour slot across NUM_FILTER cells, issuing per-filter pair valids
// aligned with cell-memory read data, then drains the filter bank before the
// next reference.
module rl_pair_gen_controller #(
    parameter int NUM_FILTER        = 7,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int RD_LATENCY        = 2,
    parameter int DRAIN_CYCLES      = 34
) (
    input logic                      clk,
    input logic                      rst,
    rl_pair_gen_controller_if.master bus
);
    localparam int PID     = PARTICLE_ID_WIDTH;
    localparam int CW      = PID + 1;
    localparam int WAIT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(RD_LATENCY - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_REF,
        S_PAIR,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      ref_count_q;
    logic [CW-1:0]      nb_count_q [NUM_FILTER];
    logic [CW-1:0]      ref_idx;
    logic [CW-1:0]      nb_idx;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               done_q;

    // Issue mask / neighbour index / reference index delayed by the memory latency.
    logic [RD_LATENCY-1:0][NUM_FILTER-1:0] mask_pipe;
    logic [RD_LATENCY-1:0][PID-1:0]        nb_pipe;
    logic [RD_LATENCY-1:0][PID-1:0]        ref_pipe;

    logic [CW-1:0]         max_count;
    logic [NUM_FILTER-1:0] issue_mask;
    logic                  line_empty;
    logic                  drain_qualify;
    logic                  latch_counts;
    logic                  pair_enter;
    logic                  issue;
    logic                  ref_advance;

    // Longest neighbour cell decides how many slots each reference walks.
    always_comb begin
        max_count = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            if (nb_count_q[i] > max_count) max_count = nb_count_q[i];
        end
    end

    // Filters whose cell holds slot nb_idx; the home cell never pairs a particle with itself.
    always_comb begin
        issue_mask = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            issue_mask[i] = (nb_idx < nb_count_q[i]);
        end
        if (nb_idx == ref_idx) issue_mask[0] = 1'b0;
    end

    assign line_empty    = ~|mask_pipe;
    assign drain_qualify = line_empty && bus.all_buffer_empty;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic and the strobes that steer the datapath counters.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_next   = state;
        latch_counts = 1'b0;
        pair_enter   = 1'b0;
        issue        = 1'b0;
        ref_advance  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    latch_counts = 1'b1;
                    state_next   = (bus.ref_count == '0) ? S_FINISH : S_LOAD_REF;
                end
            end
            S_LOAD_REF: begin
                if (wait_cnt == WAIT_LAST) begin
                    pair_enter = 1'b1;
                    state_next = S_PAIR;
                end
            end
            S_PAIR: begin
                if (nb_idx >= max_count) begin
                    state_next = S_DRAIN;
                end else if (!(|bus.back_pressure)) begin
                    issue = 1'b1;
                    if (nb_idx + CW'(1) == max_count) state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_qualify && (drain_cnt == DRAIN_LAST)) begin
                    ref_advance = 1'b1;
                    state_next  = (ref_idx + CW'(1) == ref_count_q) ? S_FINISH : S_LOAD_REF;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Latched counts, walk indices, wait/drain counters and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_count_q <= '0;
            // NOTE: the count array is only NUM_FILTER registers, so it is reset like any other flop.
            for (int i = 0; i < NUM_FILTER; i++) nb_count_q[i] <= '0;
            ref_idx     <= '0;
            nb_idx      <= '0;
            wait_cnt    <= '0;
            drain_cnt   <= '0;
            done_q      <= 1'b0;
        end else begin
            if (latch_counts) begin
                ref_count_q <= bus.ref_count;
                for (int i = 0; i < NUM_FILTER; i++) nb_count_q[i] <= bus.nb_count[i*CW +: CW];
                ref_idx <= '0;
            end else if (ref_advance) begin
                ref_idx <= ref_idx + CW'(1);
            end

            if (pair_enter)  nb_idx <= '0;
            else if (issue)  nb_idx <= nb_idx + CW'(1);

            wait_cnt <= (state == S_LOAD_REF) ? wait_cnt + 1'b1 : '0;

            if ((state == S_DRAIN) && drain_qualify && !ref_advance) drain_cnt <= drain_cnt + 1'b1;
            else                                                    drain_cnt <= '0;

            done_q <= (state == S_FINISH);
        end
    end

    // Delay line: stage 0 captures this cycle's issue, the last stage meets the read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_pipe <= '0;
            nb_pipe   <= '0;
            ref_pipe  <= '0;
        end else begin
            mask_pipe[0] <= issue ? issue_mask : '0;
            nb_pipe[0]   <= nb_idx[PID-1:0];
            ref_pipe[0]  <= ref_idx[PID-1:0];
            for (int k = 1; k < RD_LATENCY; k++) begin
                mask_pipe[k] <= mask_pipe[k-1];
                nb_pipe[k]   <= nb_pipe[k-1];
                ref_pipe[k]  <= ref_pipe[k-1];
            end
        end
    end

    assign bus.ref_rd_addr     = ref_idx[PID-1:0];
    assign bus.nb_rd_addr      = nb_idx[PID-1:0];
    assign bus.pair_valid      = mask_pipe[RD_LATENCY-1];
    assign bus.nb_particle_id  = nb_pipe[RD_LATENCY-1];
    assign bus.ref_particle_id = ref_pipe[RD_LATENCY-1];
    assign bus.busy            = (state != S_IDLE);
    assign bus.done            = done_q;
endmodule

// File: tb/tb_rl_pair_gen_controller.sv
// Directed bench for rl_pair_gen_controller: a table of whole-run scenarios
// with hand-computed totals, plus hand-written alignment and mid-run reset sequences.
module tb_rl_pair_gen_controller;
    localparam int NF  = 7;
    localparam int PID = 7;
    localparam int CW  = PID + 1;
    localparam int RDL = 2;
    localparam int DRN = 34;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rl_pair_gen_controller_if #(.NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PID)) bus ();

    rl_pair_gen_controller #(
        .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PID), .RD_LATENCY(RDL), .DRAIN_CYCLES(DRN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int               rc;     // ref_count
        logic [NF*CW-1:0] nb;     // nb_count, filter i at [i*CW +: CW]
        logic [NF-1:0]    bpm;    // back_pressure mask while the window is open
        int               bpf;    // first back-pressure cycle (cycle 0 = first after start edge)
        int               bpl;    // back-pressure length
        int               abf;    // first cycle with all_buffer_empty low
        int               abl;    // length of that low window
        int               rs;     // cycle in which a second start is pulsed (-1 = none)
        int               cyc;    // cycle index in which done is seen
        int               pairs;  // total set pair_valid bits
        int               nbs;    // sum of nb_particle_id over set bits
        int               rfs;    // sum of ref_particle_id over set bits
        int               leak;   // cycles with pair_valid != 0 inside the back-pressure window
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [NF*CW-1:0] nb_fill(input int v);
        logic [NF*CW-1:0] r;
        for (int i = 0; i < NF; i++) r[i*CW +: CW] = CW'(v);
        return r;
    endfunction

    function automatic vec_t mk(input int rc, input logic [NF*CW-1:0] nb, input logic [NF-1:0] bpm,
                                input int bpf, input int bpl, input int abf, input int abl, input int rs,
                                input int cyc, input int pairs, input int nbs, input int rfs, input int leak);
        vec_t v;
        v.rc = rc; v.nb = nb; v.bpm = bpm; v.bpf = bpf; v.bpl = bpl; v.abf = abf; v.abl = abl;
        v.rs = rs; v.cyc = cyc; v.pairs = pairs; v.nbs = nbs; v.rfs = rfs; v.leak = leak;
        return v;
    endfunction

    // Waits (bounded) for the done pulse; call from a negedge.
    task automatic wait_done(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Runs one scenario from a negedge with the controller idle; ends on a negedge.
    task automatic run_vec(input vec_t v, input int id);
        int  k, cnt, pairs, nbs, rfs, leak, extra;
        bit  seen, frozen_ok, in_bp;
        logic [PID-1:0] held;
        pairs = 0; nbs = 0; rfs = 0; leak = 0; extra = 0;
        seen = 1'b0; frozen_ok = 1'b1; held = '0;
        bus.ref_count        = CW'(v.rc);
        bus.nb_count         = v.nb;
        bus.back_pressure    = '0;
        bus.all_buffer_empty = 1'b1;
        bus.start            = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_busy_after_start", id), 64'(bus.busy), 64'd1);
        k = 0;
        while (!seen && k < 6000) begin
            cnt   = $countones(bus.pair_valid);
            pairs += cnt;
            nbs   += cnt * int'(bus.nb_particle_id);
            rfs   += cnt * int'(bus.ref_particle_id);
            in_bp = (k >= v.bpf) && (k < v.bpf + v.bpl);
            if (in_bp) begin
                if (cnt != 0) leak++;
                if (k == v.bpf) held = bus.nb_rd_addr;
                else if (bus.nb_rd_addr != held) frozen_ok = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                bus.start = (k == v.rs);
                if (k == v.rs) begin
                    bus.ref_count = CW'(5);
                    bus.nb_count  = nb_fill(5);
                end
                bus.back_pressure    = in_bp ? v.bpm : '0;
                bus.all_buffer_empty = !((k >= v.abf) && (k < v.abf + v.abl));
                @(negedge clk);
                k++;
            end
        end
        check($sformatf("v%0d_done_cycle", id), 64'(seen ? k : -1), 64'(v.cyc));
        check($sformatf("v%0d_busy_at_done", id), 64'(bus.busy), 64'd0);
        check($sformatf("v%0d_pairs", id), 64'(pairs), 64'(v.pairs));
        check($sformatf("v%0d_nb_id_sum", id), 64'(nbs), 64'(v.nbs));
        check($sformatf("v%0d_ref_id_sum", id), 64'(rfs), 64'(v.rfs));
        check($sformatf("v%0d_bp_leak", id), 64'(leak), 64'(v.leak));
        if (v.bpl > 0) check($sformatf("v%0d_nb_idx_frozen", id), 64'(frozen_ok), 64'd1);
        bus.start = 1'b0; bus.back_pressure = '0; bus.all_buffer_empty = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check($sformatf("v%0d_extra_done", id), 64'(extra), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NF*CW-1:0] nb;
        logic [NF-1:0]    exp_pv [8];
        int               extra;

        rst                  = 1'b0;
        bus.start            = 1'b0;
        bus.ref_count        = '0;
        bus.nb_count         = '0;
        bus.back_pressure    = '0;
        bus.all_buffer_empty = 1'b1;

        //           rc   nb_count      bp mask   bpf bpl abf abl  rs   cyc  pairs nbs  rfs leak
        vecs[0] = mk(2,   nb_fill(3),   7'h00,    0,  0,  0,  0,   10,  83,  40,   41,  20, 0);
        nb = '0; nb[0 +: CW] = CW'(4); nb[CW +: CW] = CW'(1);
        vecs[1] = mk(1,   nb,           7'h00,    0,  0,  0,  0,   -1,  43,  4,    6,   0,  0);
        vecs[2] = mk(1,   nb_fill(8),   7'h08,    4,  10, 0,  0,   -1,  57,  55,   196, 0,  2);
        vecs[3] = mk(1,   nb_fill(3),   7'h00,    0,  0,  27, 1,   -1,  63,  20,   21,  0,  0);
        vecs[4] = mk(0,   nb_fill(3),   7'h00,    0,  0,  0,  0,   0,   1,   0,    0,   0,  0);
        nb = '0; nb[0 +: CW] = CW'(3);
        vecs[5] = mk(3,   nb,           7'h00,    0,  0,  0,  0,   -1,  123, 6,    6,   6,  0);
        vecs[6] = mk(2,   nb_fill(0),   7'h00,    0,  0,  0,  0,   -1,  75,  0,    0,   0,  0);
        nb = '0; nb[6*CW +: CW] = CW'(128);
        vecs[7] = mk(1,   nb,           7'h00,    0,  0,  0,  0,   -1,  167, 128,  8128,0,  0);
        vecs[8] = mk(128, nb_fill(0),   7'h00,    0,  0,  0,  0,   -1,  4737,0,    0,   0,  0);
        vecs[9] = mk(1,   nb_fill(3),   7'h00,    0,  0,  0,  0,   -1,  42,  20,   21,  0,  0);

        exp_pv = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h7E, 7'h7F, 7'h7F, 7'h00};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_pair_valid", 64'(bus.pair_valid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_addrs", 64'({bus.ref_rd_addr, bus.nb_rd_addr}), 64'd0);
        check("reset_ids", 64'({bus.ref_particle_id, bus.nb_particle_id}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Cycle-exact alignment: one reference, three slots in every cell.
        bus.ref_count = CW'(1);
        bus.nb_count  = nb_fill(3);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("align_pv_c%0d", k), 64'(bus.pair_valid), 64'(exp_pv[k]));
            if (exp_pv[k] != '0) begin
                check($sformatf("align_nb_id_c%0d", k), 64'(bus.nb_particle_id), 64'(k - 4));
                check($sformatf("align_ref_id_c%0d", k), 64'(bus.ref_particle_id), 64'd0);
            end
            if (k >= 2 && k <= 4) check($sformatf("align_nb_addr_c%0d", k), 64'(bus.nb_rd_addr), 64'(k - 2));
            @(negedge clk);
        end
        wait_done("align", 60);

        // Whole-run scenario table.
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset asserted mid-PAIR clears outputs without waiting for a clock edge.
        bus.ref_count = CW'(2);
        bus.nb_count  = nb_fill(3);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_pair_valid", 64'(bus.pair_valid), 64'h7F);
        #2 rst = 1'b0;
        #1;
        check("rst_pair_valid", 64'(bus.pair_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_nb_rd_addr", 64'(bus.nb_rd_addr), 64'd0);
        check("rst_ids", 64'({bus.ref_particle_id, bus.nb_particle_id}), 64'd0);
        @(negedge clk);
        rst   = 1'b1;
        extra = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check("post_rst_quiet", 64'(extra), 64'd0);
        run_vec(vecs[1], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
